// File: rtl/usb_serial_tx_arbiter_if.sv
// Bundle between the tx byte requesters, the FIFO-PHY tx push port and the
// arbiter. Also carries read-only debug taps of the arbiter state.
interface usb_serial_tx_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int IDLETMO  = 8
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);
    localparam int IW = $clog2(IDLETMO + 1);

    // Handshake: requester n holds req_stb_i[n]/req_data_i/req_last_i stable
    // until req_rdy_o[n]; a byte moves in any cycle where stb and rdy are both
    // high, and that same cycle fifo_push_o carries it while fifo_full_i is low.
    logic [NREQ-1:0]   req_stb_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_rdy_o;
    logic [NREQ-1:0]   gnt_o;
    logic              fifo_push_o;
    logic [7:0]        fifo_data_o;
    logic              fifo_full_i;

    logic              dbg_state_o;  // 0 = IDLE, 1 = OWN
    logic [PW-1:0]     dbg_ptr_o;
    logic [BW-1:0]     dbg_bcnt_o;
    logic [IW-1:0]     dbg_icnt_o;

    modport master (
        input  req_stb_i, req_data_i, req_last_i, fifo_full_i,
        output req_rdy_o, gnt_o, fifo_push_o, fifo_data_o,
        output dbg_state_o, dbg_ptr_o, dbg_bcnt_o, dbg_icnt_o
    );

    modport slave (
        output req_stb_i, req_data_i, req_last_i, fifo_full_i,
        input  req_rdy_o, gnt_o, fifo_push_o, fifo_data_o,
        input  dbg_state_o, dbg_ptr_o, dbg_bcnt_o, dbg_icnt_o
    );
endinterface

// File: rtl/usb_serial_tx_arbiter.sv
// Message-granular round-robin arbiter for the FIFO-PHY tx push port.
// An owner keeps the port until last byte, burst limit or idle timeout.
module usb_serial_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int IDLETMO  = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    usb_serial_tx_arbiter_if.master arb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);
    localparam int IW = $clog2(IDLETMO + 1);
    localparam logic [BW-1:0] BLAST = BW'(MAXBURST - 1);
    localparam logic [IW-1:0] ILAST = IW'(IDLETMO - 1);
    localparam logic [PW-1:0] PMAX  = PW'(NREQ - 1);

    typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [IW-1:0] icnt_q, icnt_d;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cand;
    logic [PW-1:0] gidx_inc;
    logic          own_stb;
    logic          xfer;
    logic          release_c;

    // First requesting index at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!pick_found && arb.req_stb_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign gidx_inc = (gidx_q == PMAX) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        icnt_d    = icnt_q;
        own_stb   = arb.req_stb_i[gidx_q];
        xfer      = 1'b0;
        release_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                icnt_d = '0;
                if (pick_found) begin
                    state_d = S_OWN;
                    gidx_d  = pick_idx;
                end
            end
            S_OWN: begin
                xfer = own_stb & ~arb.fifo_full_i;
                if (xfer) begin
                    bcnt_d    = bcnt_q + 1'b1;
                    icnt_d    = '0;
                    release_c = arb.req_last_i[gidx_q] | (bcnt_q == BLAST);
                end else if (!own_stb) begin
                    icnt_d    = icnt_q + 1'b1;
                    release_c = (icnt_q == ILAST);
                end
                // A stall (stb high, FIFO full) leaves both counters alone.
                if (release_c) begin
                    state_d = S_IDLE;
                    ptr_d   = gidx_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst_i) begin
            xfer = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            icnt_q  <= icnt_d;
        end
    end

    assign arb.fifo_push_o = xfer;
    assign arb.req_rdy_o   = xfer ? (NREQ'(1) << gidx_q) : '0;
    assign arb.gnt_o       = (state_q == S_OWN) ? (NREQ'(1) << gidx_q) : '0;
    assign arb.fifo_data_o = ((state_q == S_OWN) && !rst_i) ?
                             arb.req_data_i[{gidx_q, 3'b000} +: 8] : 8'h00;

    assign arb.dbg_state_o = (state_q == S_OWN);
    assign arb.dbg_ptr_o   = ptr_q;
    assign arb.dbg_bcnt_o  = bcnt_q;
    assign arb.dbg_icnt_o  = icnt_q;
endmodule

// File: tb/tb_usb_serial_tx_arbiter.sv
// Bench for usb_serial_tx_arbiter: vector table, directed multi-cycle
// sequences and a randomized run against a cycle-level reference model.
module tb_usb_serial_tx_arbiter;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 16;
    localparam int IDLETMO  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_serial_tx_arbiter_if #(.NREQ(NREQ), .MAXBURST(MAXBURST), .IDLETMO(IDLETMO)) bus ();

    usb_serial_tx_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST), .IDLETMO(IDLETMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .arb   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  stb;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  gnt;
        logic        push;
        logic [7:0]  fdata;
        logic [3:0]  rdy;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vec[14];

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [31:0] d,
                                input logic [3:0] l, input logic f, input logic [3:0] g,
                                input logic p, input logic [7:0] fd, input logic [3:0] rd,
                                input logic [1:0] pt);
        vec_t v;
        v.rst = r; v.stb = s; v.data = d; v.last = l; v.full = f;
        v.gnt = g; v.push = p; v.fdata = fd; v.rdy = rd; v.ptr = pt;
        return v;
    endfunction

    // Requester drivers: per-requester byte list {last, data}.
    logic [8:0] src_mem [NREQ][256];
    int         src_wr [NREQ];
    int         src_rd [NREQ];
    bit         presenting [NREQ];
    logic       rst_drv;
    logic       full_drv;
    int         present_pct;

    // Reference model: owner index (-1 = none), rotation pointer, counts.
    int         m_owner, m_ptr, m_nbytes, m_nidle;
    logic [7:0] exp_q[$];

    logic [7:0] push_log[$];
    int         push_src[$];
    int         push_cyc[$];
    logic [3:0] gnt_log[$];
    int         cyc;
    int         l0, c0, cnt;
    logic [7:0] burst_exp[33];

    task automatic add_byte(input int n, input logic l, input logic [7:0] d);
        src_mem[n][src_wr[n]] = {l, d};
        src_wr[n]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_stb_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.fifo_full_i = 1'b0;
        repeat (2) @(posedge clk);
        rst_drv = 1'b0; full_drv = 1'b0;
        m_owner = -1; m_ptr = 0; m_nbytes = 0; m_nidle = 0;
        for (int n = 0; n < NREQ; n++) begin
            src_wr[n] = 0; src_rd[n] = 0; presenting[n] = 1'b0;
        end
        exp_q.delete(); push_log.delete(); push_src.delete(); push_cyc.delete(); gnt_log.delete();
        cyc = 0;
    endtask

    task automatic step();
        logic [NREQ-1:0]   stb, last, e_gnt, e_rdy, a_rdy;
        logic [8*NREQ-1:0] data;
        logic [7:0]        e_data;
        logic              take, done;
        int                o, src;
        @(negedge clk);
        stb = '0; last = '0; data = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (!presenting[n] && src_rd[n] < src_wr[n] && $urandom_range(99) < present_pct)
                presenting[n] = 1'b1;
            if (presenting[n]) begin
                stb[n] = 1'b1;
                data[8*n +: 8] = src_mem[n][src_rd[n]][7:0];
                last[n] = src_mem[n][src_rd[n]][8];
            end
        end
        rst = rst_drv;
        bus.req_stb_i = stb; bus.req_data_i = data; bus.req_last_i = last;
        bus.fifo_full_i = full_drv;
        #1;
        o = (m_owner < 0) ? 0 : m_owner;
        e_gnt  = (m_owner >= 0) ? (NREQ'(1) << o) : '0;
        take   = !rst_drv && (m_owner >= 0) && stb[o] && !full_drv;
        e_rdy  = take ? e_gnt : '0;
        e_data = (!rst_drv && m_owner >= 0) ? data[8*o +: 8] : 8'h00;
        chk($sformatf("c%0d_gnt", cyc), bus.gnt_o, e_gnt);
        chk($sformatf("c%0d_push", cyc), bus.fifo_push_o, take);
        chk($sformatf("c%0d_rdy", cyc), bus.req_rdy_o, e_rdy);
        chk($sformatf("c%0d_data", cyc), bus.fifo_data_o, e_data);
        chk($sformatf("c%0d_ptr", cyc), bus.dbg_ptr_o, m_ptr);
        if (take) exp_q.push_back(e_data);
        a_rdy = bus.req_rdy_o;
        gnt_log.push_back(bus.gnt_o);
        if (bus.fifo_push_o) begin
            src = -1;
            for (int n = 0; n < NREQ; n++) if (a_rdy[n]) src = n;
            push_log.push_back(bus.fifo_data_o);
            push_src.push_back(src);
            push_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL c%0d_sb: got push 0x%0h, expected no push", cyc, bus.fifo_data_o);
            end else begin
                chk($sformatf("c%0d_sb", cyc), bus.fifo_data_o, exp_q.pop_front());
            end
        end
        @(posedge clk);
        done = 1'b0;
        if (rst_drv) begin
            m_owner = -1; m_ptr = 0; m_nbytes = 0; m_nidle = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && stb[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ; m_nbytes = 0; m_nidle = 0;
                end
            end
        end else begin
            if (take) begin
                m_nbytes++; m_nidle = 0;
                done = last[o] || (m_nbytes == MAXBURST);
            end else if (!stb[o]) begin
                m_nidle++;
                done = (m_nidle == IDLETMO);
            end
            if (done) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
            end
        end
        for (int n = 0; n < NREQ; n++) begin
            if (a_rdy[n]) begin
                presenting[n] = 1'b0; src_rd[n]++;
            end
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_stb_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.fifo_full_i = 1'b0;
        rst_drv = 1'b0; full_drv = 1'b0; present_pct = 100;
        repeat (2) @(posedge clk);

        //          rst  stb      data          last    full gnt     push fdata  rdy     ptr
        vec[0]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd0);
        vec[1]  = mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd0);
        vec[2]  = mk(0, 4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd0);
        vec[3]  = mk(0, 4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0100, 1, 8'h41, 4'b0100, 2'd0);
        vec[4]  = mk(0, 4'b0100, 32'h0042_0000, 4'b0000, 0, 4'b0100, 1, 8'h42, 4'b0100, 2'd0);
        vec[5]  = mk(0, 4'b0100, 32'h0043_0000, 4'b0100, 0, 4'b0100, 1, 8'h43, 4'b0100, 2'd0);
        vec[6]  = mk(0, 4'b0011, 32'h0000_2010, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd3);
        vec[7]  = mk(0, 4'b0011, 32'h0000_2010, 4'b0000, 0, 4'b0001, 1, 8'h10, 4'b0001, 2'd3);
        vec[8]  = mk(1, 4'b0011, 32'h0000_2011, 4'b0000, 0, 4'b0001, 0, 8'h00, 4'b0000, 2'd3);
        vec[9]  = mk(0, 4'b0011, 32'h0000_2011, 4'b0001, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd0);
        vec[10] = mk(0, 4'b0011, 32'h0000_2011, 4'b0001, 0, 4'b0001, 1, 8'h11, 4'b0001, 2'd0);
        vec[11] = mk(0, 4'b0010, 32'h0000_2000, 4'b0010, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd1);
        vec[12] = mk(0, 4'b0010, 32'h0000_2000, 4'b0010, 0, 4'b0010, 1, 8'h20, 4'b0010, 2'd1);
        vec[13] = mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 2'd2);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst = vec[i].rst;
            bus.req_stb_i = vec[i].stb; bus.req_data_i = vec[i].data;
            bus.req_last_i = vec[i].last; bus.fifo_full_i = vec[i].full;
            #1;
            chk($sformatf("vec%0d_gnt", i), bus.gnt_o, vec[i].gnt);
            chk($sformatf("vec%0d_push", i), bus.fifo_push_o, vec[i].push);
            chk($sformatf("vec%0d_data", i), bus.fifo_data_o, vec[i].fdata);
            chk($sformatf("vec%0d_rdy", i), bus.req_rdy_o, vec[i].rdy);
            chk($sformatf("vec%0d_ptr", i), bus.dbg_ptr_o, vec[i].ptr);
        end

        // Rotation with single-byte messages from all requesters.
        do_reset();
        present_pct = 100;
        for (int n = 0; n < NREQ; n++)
            for (int k = 0; k < 4; k++) add_byte(n, 1'b1, 8'(16 * n + k));
        for (int c = 0; c < 60 && push_log.size() < 16; c++) step();
        chk("rot_count", push_log.size(), 16);
        for (int i = 0; i < 16 && i < push_log.size(); i++) begin
            chk($sformatf("rot_src%0d", i), push_src[i], i % 4);
            chk($sformatf("rot_byte%0d", i), push_log[i], 16 * (i % 4) + i / 4);
            if (i > 0) chk($sformatf("rot_gap%0d", i), push_cyc[i] - push_cyc[i-1], 2);
        end

        // Burst limit: requester 0 streams 40 bytes, requester 1 waits with one byte.
        do_reset();
        for (int b = 0; b < 40; b++) add_byte(0, 1'b0, 8'(b));
        add_byte(1, 1'b1, 8'hB1);
        for (int c = 0; c < 300 && push_log.size() < 41; c++) step();
        chk("burst_count", push_log.size(), 41);
        for (int i = 0; i < 16; i++) burst_exp[i] = 8'(i);
        burst_exp[16] = 8'hB1;
        for (int i = 0; i < 16; i++) burst_exp[17 + i] = 8'(16 + i);
        for (int i = 0; i < 33 && i < push_log.size(); i++)
            chk($sformatf("burst_byte%0d", i), push_log[i], burst_exp[i]);

        // Long FIFO-full stall in the middle of a burst.
        do_reset();
        for (int b = 0; b < 20; b++) add_byte(0, 1'b0, 8'(8'h60 + b));
        repeat (3) step();
        l0 = push_log.size();
        full_drv = 1'b1;
        repeat (50) step();
        #1;
        chk("stall_no_push", push_log.size(), l0);
        chk("stall_gnt", gnt_log[gnt_log.size() - 1], 4'b0001);
        chk("stall_bcnt", bus.dbg_bcnt_o, l0);
        full_drv = 1'b0;
        step();
        chk("stall_resume_count", push_log.size(), l0 + 1);
        if (push_log.size() > l0) chk("stall_resume_byte", push_log[l0], 8'h60 + l0);

        // Idle timeout with a waiting requester.
        do_reset();
        add_byte(0, 1'b0, 8'h70);
        add_byte(1, 1'b1, 8'h71);
        repeat (16) step();
        chk("tmo_first_push", push_log.size() > 0 ? push_log[0] : 8'h00, 8'h70);
        c0 = (push_cyc.size() > 0) ? push_cyc[0] : 0;
        cnt = 0;
        for (int i = c0 + 1; i <= c0 + 8 && i < gnt_log.size(); i++)
            if (gnt_log[i] == 4'b0001) cnt++;
        chk("tmo_hold_cycles", cnt, 8);
        if (gnt_log.size() > c0 + 10) begin
            chk("tmo_release", gnt_log[c0 + 9], 4'b0000);
            chk("tmo_next_grant", gnt_log[c0 + 10], 4'b0010);
        end else begin
            chk("tmo_log_len", gnt_log.size(), c0 + 11);
        end

        // Randomized traffic against the model.
        do_reset();
        present_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < NREQ; n++) begin
                if (src_rd[n] == src_wr[n] && $urandom_range(3) == 0) begin
                    int len;
                    bit nolast;
                    src_rd[n] = 0; src_wr[n] = 0;
                    len = $urandom_range(MAXBURST + 4, 1);
                    nolast = ($urandom_range(4) == 0);
                    for (int b = 0; b < len; b++)
                        add_byte(n, (b == len - 1) && !nolast, 8'($urandom_range(255)));
                end
            end
            full_drv = ($urandom_range(99) < 25);
            rst_drv  = ($urandom_range(999) == 0);
            step();
        end
        rst_drv = 1'b0;
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
